// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the round-robin stream mux
package mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Select-field width; a single channel still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pointer advance with wrap at n-1.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N        = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int SELW    = sel_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [2*N-1:0] dbl_req;
  int             start;
  int             win;

  // Scan the doubled request vector from the start point; the upper copy
  // covers the wrap-around so one linear priority pass suffices.
  always_comb begin
    dbl_req = {req, req};
    start   = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
    any     = 1'b0;
    win     = 0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!any && (i >= start) && dbl_req[i]) begin
        any = 1'b1;
        win = (i >= N) ? i - N : i;
      end
    end
  end

  // Decode the winning index to its index and one-hot forms.
  always_comb begin
    gnt_idx = win[SELW-1:0];
    for (int j = 0; j < N; j++) begin
      gnt_onehot[j] = any && (win == j);
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N:1 valid/ready stream mux with arbitration and registered output
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N        = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int SELW    = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     gnt_onehot;
  logic [SELW-1:0]  gnt_idx;
  logic             any;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // The output register can take a beat whenever it is empty or draining.
  assign load = !out_valid || out_ready;

  // Only the granted channel sees ready, and never while in reset.
  assign in_ready = (rst || !load) ? '0 : gnt_onehot;

  // Pick the granted channel's data word.
  always_comb begin
    sel_data = in_data[int'(gnt_idx) * WIDTH +: WIDTH];
  end

  // Output stage and priority pointer; a stalled beat is held untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= gnt_idx;
        if (ARB_MODE == ARB_RR) begin
          ptr <= SELW'(wrap_inc(int'(gnt_idx), N));
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - self-checking bench for rr_stream_mux in both arbitration modes
module tb_rr_stream_mux;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '1;
  logic [N*W-1:0] in_data = '0;
  logic           out_ready = 1'b1;

  logic [N-1:0]   rr_ready, fx_ready;
  logic           rr_ov, fx_ov;
  logic [W-1:0]   rr_od, fx_od;
  logic [SW-1:0]  rr_os, fx_os;

  int checks = 0;
  int errors = 0;

  // Reference state per instance (0 = round-robin, 1 = fixed priority).
  logic         m_v [2] = '{1'b0, 1'b0};
  logic [W-1:0] m_d [2] = '{32'd0, 32'd0};
  int           m_s [2] = '{0, 0};
  int           m_p [2] = '{0, 0};
  logic         n_v [2] = '{1'b0, 1'b0};
  logic [W-1:0] n_d [2] = '{32'd0, 32'd0};
  int           n_s [2] = '{0, 0};
  int           n_p [2] = '{0, 0};

  rr_stream_mux #(.WIDTH(W), .N(N), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rr_ready),
    .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_os), .out_ready(out_ready)
  );

  rr_stream_mux #(.WIDTH(W), .N(N), .ARB_MODE(1)) u_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(fx_ready),
    .out_valid(fx_ov), .out_data(fx_od), .out_sel(fx_os), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan_word(input int i);
    return in_data[i*W +: W];
  endfunction

  // Model: at mid-cycle compare the DUT against the reference state, then
  // work out what the coming edge must do from the arbitration rules.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic int           g = -1;
      automatic int           idx;
      automatic logic         ld = !m_v[d] || out_ready;
      automatic logic [N-1:0] exp_rdy = '0;
      for (int k = 0; k < N; k++) begin
        idx = (d == 0) ? (m_p[d] + k) % N : k;
        if (g < 0 && in_valid[idx]) g = idx;
      end
      if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
      chk(d ? "fx in_ready" : "rr in_ready", d ? fx_ready : rr_ready, exp_rdy);
      chk(d ? "fx out_valid" : "rr out_valid", d ? fx_ov : rr_ov, m_v[d]);
      chk(d ? "fx out_data" : "rr out_data", d ? fx_od : rr_od, m_d[d]);
      chk(d ? "fx out_sel" : "rr out_sel", d ? fx_os : rr_os, m_s[d]);
      n_v[d] = m_v[d]; n_d[d] = m_d[d]; n_s[d] = m_s[d]; n_p[d] = m_p[d];
      if (rst) begin
        n_v[d] = 1'b0; n_d[d] = '0; n_s[d] = 0; n_p[d] = 0;
      end else if (ld) begin
        if (g >= 0) begin
          n_v[d] = 1'b1; n_d[d] = chan_word(g); n_s[d] = g;
          n_p[d] = (d == 0) ? (g + 1) % N : 0;
        end else begin
          n_v[d] = 1'b0;
        end
      end
    end
  end

  // Commit the predicted state at the clock edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_v[d] <= n_v[d]; m_d[d] <= n_d[d]; m_s[d] <= n_s[d]; m_p[d] <= n_p[d];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data_base();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + i;
  endtask

  initial begin
    set_data_base();
    #1;
    // 1: reset with every input valid
    chk("t1 ready in reset", rr_ready, 4'b0000);
    cyc(); cyc();
    chk("t1 out_valid", rr_ov, 1'b0);
    chk("t1 out_data", rr_od, 32'h0);
    chk("t1 out_sel", rr_os, 2'd0);
    chk("t1 ready", rr_ready, 4'b0000);

    // 2: all valid, round-robin rotation at full rate
    rst = 1'b0;
    #1;
    chk("t2 first ready", rr_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t2 rr sel", rr_os, i % 4);
      chk("t2 rr data", rr_od, 32'hA0 + (i % 4));
      chk("t2 rr valid", rr_ov, 1'b1);
      chk("t2 fx sel", fx_os, 2'd0);
    end

    // 3: single channel then a three-cycle stall
    in_valid = 4'b0100;
    #1;
    chk("t3 ready", rr_ready, 4'b0100);
    cyc();
    chk("t3 sel", rr_os, 2'd2);
    chk("t3 data", rr_od, 32'hA2);
    out_ready = 1'b0;
    in_data[2*W +: W] = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3 stall valid", rr_ov, 1'b1);
      chk("t3 stall sel", rr_os, 2'd2);
      chk("t3 stall data", rr_od, 32'hA2);
      chk("t3 stall ready", rr_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("t3 resume ready", rr_ready, 4'b0100);
    cyc();
    chk("t3 resume data", rr_od, 32'hB2);
    set_data_base();

    // 4: pointer after ch1 favours ch3 over ch0
    in_valid = 4'b0010;
    cyc();
    chk("t4 ch1 sel", rr_os, 2'd1);
    in_valid = 4'b1001;
    #1;
    chk("t4 rr ready", rr_ready, 4'b1000);
    chk("t4 fx ready", fx_ready, 4'b0001);
    cyc();
    chk("t4 ch3 sel", rr_os, 2'd3);
    chk("t4 ch3 data", rr_od, 32'hA3);
    in_valid = 4'b0001;
    cyc();
    chk("t4 ch0 sel", rr_os, 2'd0);

    // 5: fixed priority keeps picking ch0
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5 fx ready", fx_ready, 4'b0001);
      cyc();
      chk("t5 fx sel", fx_os, 2'd0);
    end

    // 6: reset while a beat is stalled
    in_valid = 4'b0100;
    cyc();
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    cyc();
    chk("t6 pending", rr_ov, 1'b1);
    rst = 1'b1;
    cyc();
    chk("t6 rr dropped", rr_ov, 1'b0);
    chk("t6 fx dropped", fx_ov, 1'b0);
    rst = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("t6 restart ready", rr_ready, 4'b0001);
    cyc();
    chk("t6 restart sel0", rr_os, 2'd0);
    cyc();
    chk("t6 restart sel1", rr_os, 2'd1);

    // Random traffic, backpressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
